// File: rtl/frame_bank_scheduler.sv
// ============================================================================
// Module   : frame_bank_scheduler
// Purpose  : Ping-pong bank scheduler for the interlaced 1-bit frame buffer.
//            Fills one bank from the camera and hands it to the display only at
//            a display frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_bank_scheduler #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int ADDR_W     = 17,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cam_frame_start,
  input  logic                  cam_valid,
  input  logic                  cam_pixel,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  wr_data,
  output logic                  wr_bank,
  input  logic                  disp_frame_start,
  input  logic                  disp_req,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_bank,
  output logic                  reading,
  output logic                  frame_ready,
  output logic [DROP_CNT_W-1:0] dropped_frames
);

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0]     c_last     = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0]     c_addr_one = ADDR_W'(1);
  localparam logic [DROP_CNT_W-1:0] c_drop_max = '1;
  localparam logic [DROP_CNT_W-1:0] c_drop_one = DROP_CNT_W'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_HOLD = 2'd2
  } w_state_t;

  w_state_t          r_state;
  w_state_t          w_state_next;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [ADDR_W-1:0] w_addr_next;
  logic              r_fresh;
  logic              w_issue;
  logic              w_drop;
  logic              w_swap;

  // Registered fresh only: a frame finishing this cycle waits for the next boundary.
  assign w_swap = disp_frame_start & r_fresh;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= W_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_drop       = 1'b0;
    w_addr_sel   = r_next_addr;
    case (r_state)
      W_IDLE: begin
        if (cam_frame_start) begin
          w_state_next = W_FILL;
          w_addr_sel   = '0;
          w_issue      = cam_valid;
        end
      end
      W_FILL: begin
        // A new frame start aborts the short frame; its coincident pixel lands at 0.
        if (cam_frame_start) begin
          w_drop     = 1'b1;
          w_addr_sel = '0;
        end
        w_issue = cam_valid;
        if (cam_valid && w_addr_sel == c_last) begin
          w_state_next = W_HOLD;
        end
      end
      W_HOLD: begin
        w_drop = cam_frame_start;
        if (w_swap) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase

    w_addr_next = w_addr_sel;
    if (w_issue) begin
      w_addr_next = (w_addr_sel == c_last) ? '0 : w_addr_sel + c_addr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= 1'b0;
      wr_bank        <= 1'b0;
      rd_addr        <= '0;
      rd_bank        <= 1'b1;
      reading        <= 1'b0;
      frame_ready    <= 1'b0;
      dropped_frames <= '0;
      r_fresh        <= 1'b0;
      r_next_addr    <= '0;
    end else begin
      wr_en       <= w_issue;
      wr_addr     <= w_issue ? w_addr_sel : '0;
      wr_data     <= w_issue & cam_pixel;
      r_next_addr <= w_addr_next;

      if (w_drop && dropped_frames != c_drop_max) begin
        dropped_frames <= dropped_frames + c_drop_one;
      end

      if (w_swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        r_fresh     <= 1'b0;
      end else if (wr_en && wr_addr == c_last) begin
        r_fresh <= 1'b1;
      end

      if (disp_frame_start) begin
        rd_addr <= '0;
        reading <= frame_ready | w_swap;
      end else if (disp_req && reading) begin
        rd_addr <= (rd_addr == c_last) ? '0 : rd_addr + c_addr_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
// ============================================================================
// Module   : tb_frame_bank_scheduler
// Purpose  : Randomised bench for frame_bank_scheduler on a reduced 16x6 frame,
//            compared cycle by cycle against a behavioural frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_bank_scheduler;

  localparam int H    = 16;
  localparam int V    = 6;
  localparam int N    = H * V;
  localparam int AW   = 7;
  localparam int DW   = 3;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cam_frame_start, cam_valid, cam_pixel;
  logic          disp_frame_start, disp_req;
  logic          wr_en, wr_data, wr_bank, rd_bank, reading, frame_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] dropped_frames;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural view: a frame is a count of accepted pixels in a phase.
  int m_phase;   // 0 waiting for camera, 1 filling, 2 holding a full frame
  int m_count;
  int m_waddr, m_raddr, m_drops;
  bit m_wen, m_wdata, m_fresh, m_wbank, m_rbank, m_ready, m_reading, m_in_reset;

  frame_bank_scheduler #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .DROP_CNT_W(DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cam_frame_start (cam_frame_start),
    .cam_valid       (cam_valid),
    .cam_pixel       (cam_pixel),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_bank         (wr_bank),
    .disp_frame_start(disp_frame_start),
    .disp_req        (disp_req),
    .rd_addr         (rd_addr),
    .rd_bank         (rd_bank),
    .reading         (reading),
    .frame_ready     (frame_ready),
    .dropped_frames  (dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input bit pix);
    m_wen   = 1'b1;
    m_waddr = m_count;
    m_wdata = pix;
    m_count++;
    if (m_count == N) begin
      m_phase = 2;
      m_count = 0;
    end
  endtask

  task automatic model_drop();
    if (m_drops < DMAX) m_drops++;
  endtask

  task automatic model_step(input bit rstn, input bit cfs, input bit cv, input bit cp,
                            input bit dfs, input bit dreq);
    bit swap, nfresh;
    m_in_reset = !rstn;
    if (!rstn) begin
      m_phase = 0; m_count = 0; m_waddr = 0; m_raddr = 0; m_drops = 0;
      m_wen = 0; m_wdata = 0; m_fresh = 0; m_wbank = 0; m_rbank = 1;
      m_ready = 0; m_reading = 0;
      return;
    end
    swap   = dfs && m_fresh;
    nfresh = m_fresh || (m_wen && m_waddr == N - 1);
    if (swap) nfresh = 0;
    m_wen = 0;
    case (m_phase)
      0: if (cfs) begin
        m_phase = 1;
        m_count = 0;
        if (cv) model_write(cp);
      end
      1: begin
        if (cfs) begin
          model_drop();
          m_count = 0;
        end
        if (cv) model_write(cp);
      end
      default: if (cfs) model_drop();
    endcase
    if (swap) begin
      m_phase = 0;
      m_rbank = m_wbank;
      m_wbank = !m_wbank;
      m_ready = 1;
    end
    if (dfs) begin
      m_raddr   = 0;
      m_reading = m_ready;
    end else if (dreq && m_reading) begin
      m_raddr = (m_raddr + 1) % N;
    end
    m_fresh = nfresh;
  endtask

  task automatic compare_all();
    check("wr_en", 32'(wr_en), 32'(m_wen));
    if (m_wen) begin
      check("wr_addr", 32'(wr_addr), 32'(m_waddr));
      check("wr_data", 32'(wr_data), 32'(m_wdata));
    end
    if (m_in_reset) begin
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
    end
    check("wr_bank", 32'(wr_bank), 32'(m_wbank));
    check("rd_bank", 32'(rd_bank), 32'(m_rbank));
    check("rd_addr", 32'(rd_addr), 32'(m_raddr));
    check("reading", 32'(reading), 32'(m_reading));
    check("frame_ready", 32'(frame_ready), 32'(m_ready));
    check("dropped", 32'(dropped_frames), 32'(m_drops));
  endtask

  task automatic step(input bit rstn, input bit cfs, input bit cv, input bit cp,
                      input bit dfs, input bit dreq);
    reset            = rstn;
    cam_frame_start  = cfs;
    cam_valid        = cv;
    cam_pixel        = cp;
    disp_frame_start = dfs;
    disp_req         = dreq;
    @(posedge clk);
    model_step(rstn, cfs, cv, cp, dfs, dreq);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Feeds npix strobes with random gaps; stripe data is 0 on the left half of a line.
  task automatic fill(input int npix, input bit start, input bit stripe);
    if (start) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(3) == 0) step(1, 0, 0, 1'($urandom), 0, 1'($urandom));
      step(1, 0, 1, stripe ? ((i % H) >= H / 2) : 1'($urandom), 0, 0);
    end
  endtask

  initial begin
    // Reset values
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    check("reset_rd_bank", 32'(rd_bank), 32'd1);
    check("reset_wr_bank", 32'(wr_bank), 32'd0);

    // Full frame with stripe data, then handed over at the display boundary
    fill(N, 1, 1);
    idle(3);
    step(1, 0, 0, 0, 1, 0);
    check("swap1_rd_bank", 32'(rd_bank), 32'd0);
    check("swap1_wr_bank", 32'(wr_bank), 32'd1);
    check("swap1_reading", 32'(reading), 32'd1);
    check("swap1_ready", 32'(frame_ready), 32'd1);

    // Short frame restarted part way through
    fill(40, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    check("short_dropped", 32'(dropped_frames), 32'd1);
    check("short_bank", 32'(wr_bank), 32'd1);
    step(1, 0, 1, 1, 0, 0);
    check("short_restart_addr", 32'(wr_addr), 32'd0);
    fill(N - 1, 0, 0);

    // Second complete camera frame while holding: dropped, no writes
    fill(N, 1, 0);
    check("hold_dropped", 32'(dropped_frames), 32'd2);
    check("hold_bank", 32'(wr_bank), 32'd1);

    // Read path wrap on the newly swapped bank
    step(1, 0, 0, 0, 1, 0);
    check("swap2_rd_bank", 32'(rd_bank), 32'd1);
    for (int i = 0; i < N - 1; i++) step(1, 0, 0, 0, 0, 1);
    check("rd_last", 32'(rd_addr), 32'(N - 1));
    step(1, 0, 0, 0, 0, 1);
    check("rd_wrap", 32'(rd_addr), 32'd0);

    // Display boundary on the cycle of the last write does not swap
    fill(N, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    check("late_no_swap", 32'(rd_bank), 32'd1);
    idle(2);
    step(1, 0, 0, 0, 1, 0);
    check("late_swap", 32'(rd_bank), 32'd0);

    // Drop counter saturation while a full frame is held
    fill(N, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
    check("drop_sat", 32'(dropped_frames), 32'(DMAX));

    // Reset mid-fill abandons the frame
    step(1, 0, 0, 0, 1, 0);
    fill(50, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("midrst_ready", 32'(frame_ready), 32'd0);
    step(1, 0, 0, 0, 1, 0);
    check("midrst_reading", 32'(reading), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_bank", 32'(wr_bank), 32'd0);

    // Random soak
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(399) != 0, $urandom_range(79) == 0, $urandom_range(3) != 0,
           1'($urandom), $urandom_range(59) == 0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
